echo_capture_sequencer: RTL and testbench

- Per-shot timing master for the ultrasonic front end, sitting directly upstream of the ADC0 SPI master and the ADC0 sample FIFO.
- On a start request it drives a fixed-length 39.0625 kHz transmit burst, waits a blanking interval, then issues a fixed number of evenly spaced ADC conversion requests.
- Only completed conversions are gated into the FIFO write strobe. FIFO back-pressure and late conversions are reported as sticky error flags.

---
 rtl/echo_capture_sequencer_if.sv | 24 ++
 rtl/echo_capture_sequencer.sv | 136 +++++++++++++
 tb/tb_echo_capture_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/echo_capture_sequencer_if.sv
// echo_capture_sequencer_if: shot-control bundle between the sequencer, the ADC SPI master and the sample FIFO
//   master: sequencer side (drives tx_out, adc_en, fifo_wr, status and counts)
//   slave : environment side (drives on, adc_fin, fifo_full)
interface echo_capture_sequencer_if #(parameter int CW = 16);
   logic          on;
   logic          adc_fin;
   logic          fifo_full;
   logic          tx_out;
   logic          adc_en;
   logic          fifo_wr;
   logic          busy;
   logic          done;
   logic          overrun;
   logic [CW-1:0] sample_count;
   logic [CW-1:0] drop_count;
   modport master (
      input  on, adc_fin, fifo_full,
      output tx_out, adc_en, fifo_wr, busy, done, overrun, sample_count, drop_count
   );
   modport slave (
      output on, adc_fin, fifo_full,
      input  tx_out, adc_en, fifo_wr, busy, done, overrun, sample_count, drop_count
   );
endinterface

// File: rtl/echo_capture_sequencer.sv
// echo_capture_sequencer: per-shot ultrasonic timing master (TX burst, blanking, paced ADC capture)
//   CLK_40 : 40 MHz system clock
//   rst    : synchronous active-high reset
//   io     : master modport; on/adc_fin/fifo_full in, tx_out/adc_en/fifo_wr/busy/done/
//            sample_count/drop_count/overrun out
module echo_capture_sequencer #(
   parameter int TX_PERIOD     = 1024,
   parameter int TX_PULSES     = 16,
   parameter int BLANK_CYCLES  = 64,
   parameter int SAMPLE_PERIOD = 128,
   parameter int N_SAMPLES     = 4096,
   parameter int CW            = 16
) (
   input logic                        CLK_40,
   input logic                        rst,
   echo_capture_sequencer_if.master   io
);
   localparam int M1    = TX_PERIOD > SAMPLE_PERIOD ? TX_PERIOD : SAMPLE_PERIOD;
   localparam int CMAX  = M1 > BLANK_CYCLES ? M1 : BLANK_CYCLES;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam int PW    = $clog2(TX_PULSES + 1);
   localparam int SW    = $clog2(N_SAMPLES + 1);
   localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(TX_PERIOD - 1);
   localparam logic [CNT_W-1:0] TX_HALF    = CNT_W'(TX_PERIOD / 2);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [PW-1:0]    PULSE_LAST = PW'(TX_PULSES - 1);
   localparam logic [SW-1:0]    SLOTN_LAST = SW'(N_SAMPLES - 1);

   typedef enum logic [2:0] {IDLE, TX, BLANK, CAPTURE, DONE} state_t;

   state_t           st;
   logic             on_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [PW-1:0]    pulse;
   logic [SW-1:0]    slot_n;
   logic             start, tick, fin, pend_left;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // adc_en doubles as the "conversion pending" flag
   assign start      = io.on & ~on_d;
   assign cnt_inc    = cnt + 1'b1;
   assign tick       = (st == CAPTURE) && (cnt == '0);
   assign fin        = io.adc_fin & io.adc_en;
   assign pend_left  = io.adc_en & ~io.adc_fin;
   assign io.fifo_wr = fin & (st == CAPTURE);

   always_ff @(posedge CLK_40) begin
      if (rst) begin
         st              <= IDLE;
         on_d            <= 1'b1;
         cnt             <= '0;
         pulse           <= '0;
         slot_n          <= '0;
         io.tx_out       <= 1'b0;
         io.adc_en       <= 1'b0;
         io.busy         <= 1'b0;
         io.done         <= 1'b0;
         io.overrun      <= 1'b0;
         io.sample_count <= '0;
         io.drop_count   <= '0;
      end else begin
         on_d <= io.on;
         if (st == CAPTURE) begin
            if (fin) io.sample_count <= sat_inc(io.sample_count);
            // a fin landing on a tick frees the slot, so only a still-pending or full tick drops
            if (tick && (io.fifo_full || pend_left)) begin
               io.drop_count <= sat_inc(io.drop_count);
               io.overrun    <= 1'b1;
            end
            io.adc_en <= pend_left | (tick & ~io.fifo_full);
         end
         case (st)
            IDLE: if (start) begin
               st              <= TX;
               cnt             <= '0;
               pulse           <= '0;
               io.tx_out       <= 1'b1;
               io.busy         <= 1'b1;
               io.sample_count <= '0;
               io.drop_count   <= '0;
               io.overrun      <= 1'b0;
            end
            TX: begin
               cnt       <= (cnt == TX_LAST) ? '0 : cnt_inc;
               io.tx_out <= (cnt == TX_LAST) || (cnt_inc < TX_HALF);
               if (cnt == TX_LAST) begin
                  pulse <= pulse + 1'b1;
                  if (pulse == PULSE_LAST) begin
                     io.tx_out <= 1'b0;
                     slot_n    <= '0;
                     st        <= (BLANK_CYCLES == 0) ? CAPTURE : BLANK;
                  end
               end
            end
            BLANK: begin
               cnt <= cnt_inc;
               if (cnt == BLANK_LAST) begin
                  st     <= CAPTURE;
                  cnt    <= '0;
                  slot_n <= '0;
               end
            end
            CAPTURE: begin
               cnt <= (cnt == SLOT_LAST) ? '0 : cnt_inc;
               if (cnt == SLOT_LAST) begin
                  slot_n <= slot_n + 1'b1;
                  if (slot_n == SLOTN_LAST) begin
                     st        <= DONE;
                     io.adc_en <= 1'b0;
                     io.busy   <= 1'b0;
                     io.done   <= 1'b1;
                  end
               end
            end
            DONE: if (!io.on) begin
               st      <= IDLE;
               io.done <= 1'b0;
            end
            default: st <= IDLE;
         endcase
         // abort overrides any transition taken above
         if (st != IDLE && st != DONE && !io.on) begin
            st        <= IDLE;
            io.tx_out <= 1'b0;
            io.adc_en <= 1'b0;
            io.busy   <= 1'b0;
            io.done   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_echo_capture_sequencer.sv
// tb_echo_capture_sequencer: self-checking bench for echo_capture_sequencer with small shot parameters
module tb_echo_capture_sequencer;
   localparam int SP   = 16;
   localparam int NS   = 4;
   localparam int CAP0 = 20;
   localparam logic [19:0] TX_EXP = 20'b1111_0000_1111_0000_0000;

   typedef struct {
      int         lat;
      logic [3:0] mask;
      int         es;
      int         ed;
      logic       eo;
   } vec_t;

   logic CLK_40 = 1'b0;
   logic rst;
   logic spi_fin, man_fin, en_prev;
   logic [3:0]  full_mask;
   logic [19:0] tx_hist;
   int cyc, wr_cnt, en_rises, spi_lat, spi_left;
   int checks = 0;
   int failures = 0;
   vec_t tbl [5];

   echo_capture_sequencer_if #(.CW(16)) io ();

   echo_capture_sequencer #(
      .TX_PERIOD(8), .TX_PULSES(2), .BLANK_CYCLES(4),
      .SAMPLE_PERIOD(SP), .N_SAMPLES(NS), .CW(16)
   ) dut (
      .CLK_40(CLK_40),
      .rst(rst),
      .io(io)
   );

   assign io.adc_fin = spi_fin | man_fin;

   always #5 CLK_40 = ~CLK_40;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // SPI master model: latches a request when idle and adc_en is high, fins spi_lat cycles later
   task automatic spi_step();
      spi_fin = 1'b0;
      if (spi_left > 0) begin
         spi_left--;
         if (spi_left == 0) spi_fin = 1'b1;
      end else if (io.adc_en === 1'b1 && spi_lat > 0) spi_left = spi_lat;
   endtask

   task automatic cyc_step();
      @(negedge CLK_40);
      cyc++;
      io.fifo_full = 1'b0;
      if (cyc >= CAP0 && cyc < CAP0 + NS * SP && (cyc - CAP0) % SP == 0)
         io.fifo_full = full_mask[(cyc - CAP0) / SP];
      spi_step();
      #1;
      if (io.fifo_wr === 1'b1) wr_cnt++;
      if (io.adc_en === 1'b1 && !en_prev) en_rises++;
      en_prev = io.adc_en;
      if (cyc >= 0 && cyc < 20) tx_hist = {tx_hist[18:0], io.tx_out};
   endtask

   task automatic start_shot(input int lat, input logic [3:0] m);
      spi_lat = lat; full_mask = m; spi_left = 0; spi_fin = 1'b0;
      wr_cnt = 0; en_rises = 0; en_prev = 1'b0; tx_hist = '0;
      @(negedge CLK_40);
      io.fifo_full = 1'b0;
      io.on = 1'b1;
      cyc = -1;
   endtask

   task automatic end_shot();
      io.on = 1'b0;
      repeat (3) cyc_step();
   endtask

   // shot-level reference: walk the sample slots with a single outstanding-conversion deadline
   function automatic void model(input int lat, input logic [3:0] m,
                                 output int s, output int d, output int p);
      int fin_t, t;
      s = 0; d = 0; p = 0; fin_t = 0;
      for (int k = 0; k < NS; k++) begin
         t = k * SP;
         if (p != 0 && fin_t <= t) begin s++; p = 0; end
         if (m[k] || p != 0) d++;
         else begin p = 1; fin_t = t + 1 + lat; end
      end
      if (p != 0 && fin_t <= NS * SP - 1) begin s++; p = 0; end
   endfunction

   initial begin
      int lat, s, d, p;
      logic [3:0] m;
      tbl[0] = '{5,  4'b0000, 4, 0, 1'b0};
      tbl[1] = '{5,  4'b0010, 3, 1, 1'b1};
      tbl[2] = '{20, 4'b0000, 2, 2, 1'b1};
      tbl[3] = '{15, 4'b0000, 3, 0, 1'b0};
      tbl[4] = '{20, 4'b0010, 2, 2, 1'b1};
      rst = 1'b1; man_fin = 1'b0; spi_fin = 1'b0; spi_lat = 0; spi_left = 0;
      io.on = 1'b0; io.fifo_full = 1'b0; full_mask = '0; cyc = 0;
      repeat (3) @(posedge CLK_40);
      #1;
      chk("rst_tx_out", io.tx_out, 0);
      chk("rst_adc_en", io.adc_en, 0);
      chk("rst_fifo_wr", io.fifo_wr, 0);
      chk("rst_busy", io.busy, 0);
      chk("rst_done", io.done, 0);
      chk("rst_overrun", io.overrun, 0);
      chk("rst_samples", io.sample_count, 0);
      chk("rst_drops", io.drop_count, 0);
      @(negedge CLK_40);
      rst = 1'b0;
      repeat (2) @(negedge CLK_40);

      for (int i = 0; i < 5; i++) begin
         start_shot(tbl[i].lat, tbl[i].mask);
         repeat (130) cyc_step();
         chk($sformatf("tbl%0d_tx_pattern", i), 32'(tx_hist), 32'(TX_EXP));
         chk($sformatf("tbl%0d_done", i), io.done, 1);
         chk($sformatf("tbl%0d_samples", i), io.sample_count, tbl[i].es);
         chk($sformatf("tbl%0d_drops", i), io.drop_count, tbl[i].ed);
         chk($sformatf("tbl%0d_overrun", i), io.overrun, tbl[i].eo);
         chk($sformatf("tbl%0d_fifo_wr", i), wr_cnt, tbl[i].es);
         if (i == 0) chk("tbl0_requests", en_rises, 4);
         end_shot();
         chk($sformatf("tbl%0d_idle", i), io.done, 0);
      end

      start_shot(15, 4'b0000);
      while (cyc < CAP0 + SP) cyc_step();
      chk("sim_fifo_wr", io.fifo_wr, 1);
      chk("sim_before", io.sample_count, 0);
      cyc_step();
      chk("sim_samples", io.sample_count, 1);
      chk("sim_drops", io.drop_count, 0);
      chk("sim_reissue", io.adc_en, 1);
      end_shot();

      for (int r = 0; r < 8; r++) begin
         lat = int'($urandom_range(1, 40));
         m = 4'($urandom_range(0, 15));
         model(lat, m, s, d, p);
         start_shot(lat, m);
         repeat (130) cyc_step();
         chk($sformatf("rnd%0d_samples lat=%0d mask=%b", r, lat, m), io.sample_count, s);
         chk($sformatf("rnd%0d_drops", r), io.drop_count, d);
         chk($sformatf("rnd%0d_overrun", r), io.overrun, d > 0);
         chk($sformatf("rnd%0d_fifo_wr", r), wr_cnt, s);
         chk($sformatf("rnd%0d_invariant", r), io.sample_count + io.drop_count + p, NS);
         end_shot();
      end

      start_shot(5, 4'b0001);
      while (cyc < 70) cyc_step();
      io.on = 1'b0;
      cyc_step();
      chk("abort_busy", io.busy, 0);
      chk("abort_adc_en", io.adc_en, 0);
      chk("abort_samples", io.sample_count, 2);
      chk("abort_drops", io.drop_count, 1);
      wr_cnt = 0;
      repeat (20) cyc_step();
      chk("abort_late_fin_wr", wr_cnt, 0);
      chk("abort_hold", io.sample_count, 2);
      chk("abort_ovr_hold", io.overrun, 1);
      start_shot(5, 4'b0000);
      cyc_step();
      chk("restart_busy", io.busy, 1);
      chk("restart_tx", io.tx_out, 1);
      chk("restart_samples", io.sample_count, 0);
      chk("restart_drops", io.drop_count, 0);
      chk("restart_overrun", io.overrun, 0);
      end_shot();

      start_shot(0, 4'b0000);
      while (cyc < 2) cyc_step();
      chk("pre_rst_tx", io.tx_out, 1);
      rst = 1'b1;
      cyc_step();
      chk("midtx_rst_tx", io.tx_out, 0);
      chk("midtx_rst_busy", io.busy, 0);
      chk("midtx_rst_adc_en", io.adc_en, 0);
      chk("midtx_rst_done", io.done, 0);
      rst = 1'b0;
      repeat (30) cyc_step();
      chk("on_held_no_shot", io.busy, 0);
      chk("on_held_no_tx", io.tx_out, 0);
      io.on = 1'b0;
      cyc_step();
      io.on = 1'b1;
      cyc_step();
      chk("toggle_starts", io.busy, 1);
      end_shot();

      @(negedge CLK_40);
      man_fin = 1'b1;
      #1;
      chk("stray_fin_wr", io.fifo_wr, 0);
      @(posedge CLK_40);
      #1;
      man_fin = 1'b0;
      chk("stray_fin_count", io.sample_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
